// File: rtl/crc_mem_array.sv
// crc_mem_array: DEPTH x DATA_WIDTH memory, each word stored with a CRC_W-bit
// CRC. Reads are checked and single-bit errors (data or CRC) are corrected via
// a syndrome table. Saturating counters track corrected/uncorrectable reads.
// Optional background scrubber is built when CRC_MEM_SCRUB_EN is defined.
module crc_mem_array #(
    parameter int              DATA_WIDTH     = 32,
    parameter int              DEPTH          = 16,
    parameter int              CRC_W          = 8,
    parameter logic [CRC_W-1:0] POLY          = 8'h07,
    parameter int              OUTPUT_FF      = 1,
    parameter int              SCRUB_INTERVAL = 64,
    localparam int             AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [DATA_WIDTH+CRC_W-1:0] inj_mask,
    input  logic                        rd_req,
    input  logic [AW-1:0]               rd_addr,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        err_detected,
    output logic                        err_corrected,
    output logic                        err_uncorrectable,
    output logic [15:0]                 corr_cnt,
    output logic [15:0]                 uncorr_cnt
);
    localparam int CW = DATA_WIDTH + CRC_W;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  det;
        logic                  corr;
        logic                  unc;
    } dec_t;

    // MSB-first CRC, init 0, no reflection, no final XOR.
    function automatic logic [CRC_W-1:0] crc_f(input logic [DATA_WIDTH-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = c << 1;
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    // Syndrome of a single flip at codeword bit k ({data,crc} order).
    function automatic logic [CW-1:0][CRC_W-1:0] syn_tab_f();
        logic [CW-1:0][CRC_W-1:0] t;
        logic [DATA_WIDTH-1:0]    e;
        for (int k = 0; k < CW; k++) begin
            if (k < CRC_W) begin
                t[k] = CRC_W'(1) << k;
            end else begin
                e = '0;
                e[k-CRC_W] = 1'b1;
                t[k] = crc_f(e);
            end
        end
        return t;
    endfunction

    localparam logic [CW-1:0][CRC_W-1:0] SYN_TAB = syn_tab_f();

    function automatic bit syn_ok_f();
        bit ok;
        ok = 1'b1;
        for (int a = 0; a < CW; a++) begin
            if (SYN_TAB[a] == '0) ok = 1'b0;
            for (int b = a + 1; b < CW; b++)
                if (SYN_TAB[a] == SYN_TAB[b]) ok = 1'b0;
        end
        return ok;
    endfunction

    localparam bit SYN_OK = syn_ok_f();

    if (!SYN_OK) begin : g_syn_chk
        $error("crc_mem_array: single-bit syndromes are not distinct and nonzero");
    end
    if (SCRUB_INTERVAL < 1) begin : g_int_chk
        $error("crc_mem_array: SCRUB_INTERVAL must be at least 1");
    end

    // Syndrome zero never matches the table since every entry is nonzero.
    function automatic dec_t decode_f(input logic [CW-1:0] cw);
        logic [CRC_W-1:0] syn;
        logic [CW-1:0]    fixed;
        dec_t             r;
        syn   = crc_f(cw[CW-1:CRC_W]) ^ cw[CRC_W-1:0];
        fixed = cw;
        r     = '0;
        for (int k = 0; k < CW; k++) begin
            if (syn == SYN_TAB[k]) begin
                fixed[k] = ~cw[k];
                r.corr   = 1'b1;
            end
        end
        r.det  = |syn;
        r.unc  = r.det & ~r.corr;
        r.data = fixed[CW-1:CRC_W];
        return r;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [CW-1:0] mem_q [DEPTH];
    logic [CW-1:0] wr_cw;
    logic          sc_we, sc_corr, sc_unc;
    logic [AW-1:0] sc_ptr;
    logic [CW-1:0] sc_cw;

`ifdef CRC_MEM_SCRUB_EN
    localparam logic [1:0] SC_IDLE = 2'd0;
    localparam logic [1:0] SC_WAIT = 2'd1;
    localparam logic [1:0] SC_READ = 2'd2;
    localparam logic [1:0] SC_FIX  = 2'd3;
    localparam int         CNT_W   = $clog2(SCRUB_INTERVAL + 1);

    logic [1:0]       sc_state_q, sc_state_d;
    logic [CNT_W-1:0] sc_cnt_q, sc_cnt_d;
    logic [AW-1:0]    sc_ptr_q, sc_ptr_d;
    logic             sc_fix_q, sc_fix_d;
    logic [CW-1:0]    sc_cw_q, sc_cw_d;
    dec_t             sc_dec;

    // Scrubber sequencing: wait for an idle window, check one word, repair it.
    always_comb begin
        sc_state_d = sc_state_q;
        sc_cnt_d   = sc_cnt_q;
        sc_ptr_d   = sc_ptr_q;
        sc_fix_d   = sc_fix_q;
        sc_cw_d    = sc_cw_q;
        sc_corr    = 1'b0;
        sc_unc     = 1'b0;
        sc_we      = 1'b0;
        sc_dec     = decode_f(mem_q[sc_ptr_q]);
        case (sc_state_q)
            SC_IDLE: begin
                sc_cnt_d   = '0;
                sc_state_d = SC_WAIT;
            end
            SC_WAIT: begin
                if (wr_en || rd_req) begin
                    sc_cnt_d = '0;
                end else if (sc_cnt_q == CNT_W'(SCRUB_INTERVAL - 1)) begin
                    sc_cnt_d   = '0;
                    sc_state_d = SC_READ;
                end else begin
                    sc_cnt_d = sc_cnt_q + 1'b1;
                end
            end
            SC_READ: begin
                sc_corr    = sc_dec.corr;
                sc_unc     = sc_dec.det & ~sc_dec.corr;
                // A write landing on this word now makes the repair stale.
                sc_fix_d   = sc_dec.corr && !(wr_en && wr_addr == sc_ptr_q);
                sc_cw_d    = {sc_dec.data, crc_f(sc_dec.data)};
                sc_state_d = SC_FIX;
            end
            default: begin
                sc_we      = sc_fix_q && !(wr_en && wr_addr == sc_ptr_q);
                sc_fix_d   = 1'b0;
                sc_ptr_d   = (sc_ptr_q == AW'(DEPTH - 1)) ? '0 : sc_ptr_q + 1'b1;
                sc_state_d = SC_IDLE;
            end
        endcase
    end

    // Scrubber state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_state_q <= SC_IDLE;
            sc_cnt_q   <= '0;
            sc_ptr_q   <= '0;
            sc_fix_q   <= 1'b0;
            sc_cw_q    <= '0;
        end else begin
            sc_state_q <= sc_state_d;
            sc_cnt_q   <= sc_cnt_d;
            sc_ptr_q   <= sc_ptr_d;
            sc_fix_q   <= sc_fix_d;
            sc_cw_q    <= sc_cw_d;
        end
    end

    assign sc_ptr = sc_ptr_q;
    assign sc_cw  = sc_cw_q;
`else
    assign sc_we   = 1'b0;
    assign sc_corr = 1'b0;
    assign sc_unc  = 1'b0;
    assign sc_ptr  = '0;
    assign sc_cw   = '0;
`endif

    // Encoded write word, with the fault-injection mask applied.
    always_comb begin
        wr_cw = {wr_data, crc_f(wr_data)} ^ inj_mask;
    end

    // Storage array; a functional write is applied last so it wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (sc_we) mem_q[sc_ptr] <= sc_cw;
            if (wr_en) mem_q[wr_addr] <= wr_cw;
        end
    end

    logic          rd_vld_q, rd_vld_d;
    logic [CW-1:0] rd_cw_q, rd_cw_d;
    dec_t          rd_dec;

    // Read capture: sampling the array at the edge gives read-before-write.
    always_comb begin
        rd_vld_d = rd_req;
        rd_cw_d  = rd_req ? mem_q[rd_addr] : rd_cw_q;
        rd_dec   = decode_f(rd_cw_q);
    end

    // Read stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rd_cw_q  <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_cw_q  <= rd_cw_d;
        end
    end

    logic [15:0] corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;

    // Counters take functional and scrub events, which can coincide.
    always_comb begin
        corr_cnt_d   = sat_add(corr_cnt_q,
                               {1'b0, rd_vld_q & rd_dec.corr} + {1'b0, sc_corr});
        uncorr_cnt_d = sat_add(uncorr_cnt_q,
                               {1'b0, rd_vld_q & rd_dec.unc} + {1'b0, sc_unc});
    end

    // Error counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

    if (OUTPUT_FF != 0) begin : g_out_ff
        logic                  vld_q, vld_d, det_q, det_d, cor_q, cor_d, unc_q, unc_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;

        // Output stage: data held between reads, flags only with valid.
        always_comb begin
            vld_d  = rd_vld_q;
            data_d = rd_vld_q ? rd_dec.data : data_q;
            det_d  = rd_vld_q & rd_dec.det;
            cor_d  = rd_vld_q & rd_dec.corr;
            unc_d  = rd_vld_q & rd_dec.unc;
        end

        // Output register stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                det_q  <= 1'b0;
                cor_q  <= 1'b0;
                unc_q  <= 1'b0;
            end else begin
                vld_q  <= vld_d;
                data_q <= data_d;
                det_q  <= det_d;
                cor_q  <= cor_d;
                unc_q  <= unc_d;
            end
        end

        assign rd_valid          = vld_q;
        assign rd_data           = data_q;
        assign err_detected      = det_q;
        assign err_corrected     = cor_q;
        assign err_uncorrectable = unc_q;
    end else begin : g_out_comb
        assign rd_valid          = rd_vld_q;
        assign rd_data           = rd_dec.data;
        assign err_detected      = rd_vld_q & rd_dec.det;
        assign err_corrected     = rd_vld_q & rd_dec.corr;
        assign err_uncorrectable = rd_vld_q & rd_dec.unc;
    end
endmodule
